pio_write_scheduler: RTL and testbench



---
 rtl/pio_sched_pkg.sv | 23 ++
 rtl/pio_write_scheduler_rr_arbiter.sv | 43 ++++
 rtl/pio_write_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pio_write_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_sched_pkg.sv
// pio_sched_pkg
// Shared types and constants for the PIO write scheduler.
//   pio_sched_state_t : scheduler FSM states (READ only reachable with readback)
//   PIO_DATA_ADDR     : Avalon address of the PIO data register
//   PIO_WRITEDATA_W   : Avalon writedata width
//   cnt_width()       : dwell counter width, never below 1 bit
package pio_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DWELL = 2'd3
    } pio_sched_state_t;

    localparam logic [1:0] PIO_DATA_ADDR   = 2'd0;
    localparam int         PIO_WRITEDATA_W = 32;

    function automatic int cnt_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/pio_write_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. Searches from last_i+1 upward
// with wrap-around and grants the first asserted request.
// Ports:
//   req_i     in  NUM_REQ : request vector
//   last_i    in  IDX_W   : index granted most recently
//   gnt_oh_o  out NUM_REQ : one-hot grant (all zero when no request)
//   gnt_idx_o out IDX_W   : encoded grant index (0 when no request)
//   any_o     out 1       : at least one request is asserted
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        // Offsets 1..NUM_REQ visit every index once, ending on last_i itself,
        // so a lone requester that was just served can be granted again.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                gnt_oh_o[cand]  = 1'b1;
                gnt_idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/pio_write_scheduler.sv
// pio_write_scheduler
// Round-robin scheduler sharing one Avalon-MM output PIO among NUM_REQ
// requesters. One value is accepted per IDLE cycle, written to the PIO data
// register in the next cycle, then the bus idles for DWELL_CYCLES so the value
// stays on out_port for a guaranteed minimum.
// Optional feature macro: PIO_SCHED_READBACK_EN adds a READ cycle after every
// write that compares PIO readdata with the written value (sticky err flag).
// Handshake: req_valid[i] is held by requester i until accepted; req_ready is
// a one-hot strobe asserted combinationally in IDLE only, and a transfer
// happens in the cycle where req_valid[i] & req_ready[i] are both high.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   req_valid/data  : requester values, requester i at [i*DATA_W +: DATA_W]
//   req_ready       : one-hot accept strobe
//   pio_*           : Avalon-MM master towards the PIO slave
//   busy            : high whenever the FSM is not in IDLE
//   err_clr/err     : readback error clear / sticky flag (readback only)
//   state_o         : current FSM state for observation
module pio_write_scheduler
    import pio_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 10,
    parameter int DWELL_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [1:0]                  pio_address,
    output logic                        pio_chipselect,
    output logic                        pio_write_n,
    output logic [PIO_WRITEDATA_W-1:0]  pio_writedata,
    input  logic [PIO_WRITEDATA_W-1:0]  pio_readdata,
    output logic                        busy,
`ifdef PIO_SCHED_READBACK_EN
    input  logic                        err_clr,
    output logic                        err,
`endif
    output pio_sched_state_t            state_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LOAD =
        (DWELL_CYCLES > 0) ? CNT_W'(DWELL_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    pio_sched_state_t           state_q;
    logic                       cs_q;
    logic                       write_n_q;
    logic [PIO_WRITEDATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [IDX_W-1:0]           last_q;

    logic [NUM_REQ-1:0]         gnt_oh;
    logic [IDX_W-1:0]           gnt_idx;
    logic                       gnt_any;
    logic [DATA_W-1:0]          gnt_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                gnt_data = gnt_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef PIO_SCHED_READBACK_EN
    logic err_q;
    logic rd_mismatch;
    assign rd_mismatch = (pio_readdata[DATA_W-1:0] != wdata_q[DATA_W-1:0]);
    assign err         = err_q;
`endif

    // pio_readdata is only compared in readback builds; the reduction keeps
    // the whole bus referenced in every build.
    logic unused_rd;
    assign unused_rd = ^pio_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            wdata_q   <= '0;
            cnt_q     <= '0;
            last_q    <= LAST_RST;
`ifdef PIO_SCHED_READBACK_EN
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef PIO_SCHED_READBACK_EN
            // A mismatch in READ is assigned later in this block and wins.
            if (err_clr) begin
                err_q <= 1'b0;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        last_q    <= gnt_idx;
                        wdata_q   <= PIO_WRITEDATA_W'(gnt_data);
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    write_n_q <= 1'b1;
`ifdef PIO_SCHED_READBACK_EN
                    // chipselect stays high for the read-back access.
                    state_q   <= S_READ;
`else
                    cs_q      <= 1'b0;
                    if (DWELL_CYCLES > 0) begin
                        cnt_q   <= DWELL_LOAD;
                        state_q <= S_DWELL;
                    end else begin
                        state_q <= S_IDLE;
                    end
`endif
                end
                S_READ: begin
                    cs_q <= 1'b0;
`ifdef PIO_SCHED_READBACK_EN
                    if (rd_mismatch) begin
                        err_q <= 1'b1;
                    end
                    if (DWELL_CYCLES > 0) begin
                        cnt_q   <= DWELL_LOAD;
                        state_q <= S_DWELL;
                    end else begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_DWELL: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by reset_n so nothing is accepted while reset is held.
    assign req_ready      = (state_q == S_IDLE && reset_n) ? gnt_oh : '0;
    assign pio_address    = PIO_DATA_ADDR;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = write_n_q;
    assign pio_writedata  = wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign state_o        = state_q;

endmodule

// File: tb/tb_pio_write_scheduler.sv
// tb_pio_write_scheduler
// Two scheduler instances (DWELL_CYCLES 0 and 5) driven by shared requester
// inputs, each attached to a small PIO slave model. A cycle-level reference
// model built from grant times and a round-robin pointer predicts every output.
// Also builds with PIO_SCHED_READBACK_EN defined.
module tb_pio_write_scheduler;
    import pio_sched_pkg::*;

`ifdef PIO_SCHED_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [39:0] req_data;
    logic        stuck;
    logic        err_clr;

    logic [3:0]  ready [2];
    logic [1:0]  addr  [2];
    logic        cs    [2];
    logic        wn    [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        busy  [2];
    logic        err   [2];
    pio_sched_state_t st [2];
    logic [9:0]  pio_out [2];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    pio_write_scheduler #(.NUM_REQ(4), .DATA_W(10), .DWELL_CYCLES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready[0]), .pio_address(addr[0]), .pio_chipselect(cs[0]),
        .pio_write_n(wn[0]), .pio_writedata(wd[0]), .pio_readdata(rdata[0]),
        .busy(busy[0]),
`ifdef PIO_SCHED_READBACK_EN
        .err_clr(err_clr), .err(err[0]),
`endif
        .state_o(st[0]));

    pio_write_scheduler #(.NUM_REQ(4), .DATA_W(10), .DWELL_CYCLES(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready[1]), .pio_address(addr[1]), .pio_chipselect(cs[1]),
        .pio_write_n(wn[1]), .pio_writedata(wd[1]), .pio_readdata(rdata[1]),
        .busy(busy[1]),
`ifdef PIO_SCHED_READBACK_EN
        .err_clr(err_clr), .err(err[1]),
`endif
        .state_o(st[1]));

`ifndef PIO_SCHED_READBACK_EN
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
`endif

    // PIO slave models: out_port register resetting to 0x3FF.
    for (genvar d = 0; d < 2; d++) begin : g_pio
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) pio_out[d] <= 10'h3FF;
            else if (cs[d] && !wn[d]) pio_out[d] <= wd[d][9:0];
        end
        assign rdata[d] = stuck ? 32'h0000_03FF : {22'b0, pio_out[d]};
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];

    // reference model state, per instance
    int          dwell   [2] = '{0, 5};
    int          idle_at [2];
    int          wr_cyc  [2];
    int          rd_cyc  [2];
    int          m_last  [2];
    logic [9:0]  m_pend  [2];
    logic [9:0]  m_out   [2];
    logic [31:0] m_wd    [2];
    logic        m_err   [2];

    // samples of the last completed cycle
    logic [3:0]  s_ready [2];
    logic        s_cs    [2];
    logic        s_wn    [2];
    logic [31:0] s_wd    [2];
    logic        s_busy  [2];
    logic        s_err   [2];
    logic [9:0]  s_out   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int d);
        logic [3:0]  e_ready;
        logic        e_cs, e_wn, e_busy;
        int          g;
        string       p;
        p = $sformatf("d%0d", d);
        if (!reset_n) begin
            idle_at[d] = cyc + 1;
            wr_cyc[d]  = -1;
            rd_cyc[d]  = -1;
            m_last[d]  = 3;
            m_wd[d]    = '0;
            m_err[d]   = 1'b0;
            m_out[d]   = 10'h3FF;
            if (d == 0) exp_q0.delete(); else exp_q1.delete();
            check({p, " rst ready"}, 32'(s_ready[d]), 32'h0);
            check({p, " rst cs"},    32'(s_cs[d]),    32'h0);
            check({p, " rst wn"},    32'(s_wn[d]),    32'h1);
            check({p, " rst wd"},    s_wd[d],         32'h0);
            check({p, " rst busy"},  32'(s_busy[d]),  32'h0);
            check({p, " rst err"},   32'(s_err[d]),   32'h0);
            return;
        end
        e_busy = !(cyc >= idle_at[d]);
        e_cs   = (cyc == wr_cyc[d]) || (cyc == rd_cyc[d]);
        e_wn   = (cyc != wr_cyc[d]);
        if (cyc == wr_cyc[d]) m_wd[d] = {22'b0, m_pend[d]};
        e_ready = '0;
        if (!e_busy && (|req_valid)) begin
            g = -1;
            for (int j = 1; j <= 4; j++) begin
                int idx;
                idx = (m_last[d] + j) % 4;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            e_ready[g] = 1'b1;
            m_pend[d]  = req_data[g*10 +: 10];
            m_last[d]  = g;
            wr_cyc[d]  = cyc + 1;
            rd_cyc[d]  = (RB != 0) ? cyc + 2 : -1;
            idle_at[d] = cyc + 2 + RB + dwell[d];
        end
        check({p, " ready"}, 32'(s_ready[d]), 32'(e_ready));
        check({p, " cs"},    32'(s_cs[d]),    32'(e_cs));
        check({p, " wn"},    32'(s_wn[d]),    32'(e_wn));
        check({p, " wd"},    s_wd[d],         m_wd[d]);
        check({p, " busy"},  32'(s_busy[d]),  32'(e_busy));
        check({p, " out"},   32'(s_out[d]),   32'(m_out[d]));
        check({p, " addr"},  32'(addr[d]),    32'h0);
        check({p, " err"},   32'(s_err[d]),   32'(m_err[d]));
        if (cyc == rd_cyc[d] && ((stuck ? 10'h3FF : m_pend[d]) != m_pend[d])) m_err[d] = 1'b1;
        else if (RB != 0 && err_clr) m_err[d] = 1'b0;
        // scoreboard: model queues the value on its write cycle, DUT strobe pops it
        if (cyc == wr_cyc[d]) begin
            m_out[d] = m_pend[d];
            if (d == 0) exp_q0.push_back(m_pend[d]); else exp_q1.push_back(m_pend[d]);
        end
        if (s_cs[d] && !s_wn[d]) begin
            if (d == 0) begin
                if (exp_q0.size() == 0) check({p, " unexpected write"}, s_wd[d], 32'hFFFF_FFFF);
                else check({p, " sb data"}, s_wd[d], {22'b0, exp_q0.pop_front()});
            end else begin
                if (exp_q1.size() == 0) check({p, " unexpected write"}, s_wd[d], 32'hFFFF_FFFF);
                else check({p, " sb data"}, s_wd[d], {22'b0, exp_q1.pop_front()});
            end
        end
        if (d == 0 && exp_q0.size() != 0) begin
            check({p, " missing write"}, 32'(exp_q0.size()), 32'h0);
            exp_q0.delete();
        end
        if (d == 1 && exp_q1.size() != 0) begin
            check({p, " missing write"}, 32'(exp_q1.size()), 32'h0);
            exp_q1.delete();
        end
    endtask

    // one clock cycle: inputs are already applied, sample at negedge, advance
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            s_ready[d] = ready[d];
            s_cs[d]    = cs[d];
            s_wn[d]    = wn[d];
            s_wd[d]    = wd[d];
            s_busy[d]  = busy[d];
            s_err[d]   = err[d];
            s_out[d]   = pio_out[d];
            model_step(d);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [39:0] data;
        logic [3:0]  ready;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic        busy;
    } vec_t;

    vec_t tbl [18];

    task automatic row(input int i, input logic r, input logic [3:0] v, input logic [39:0] dt,
                       input logic [3:0] rd, input logic c, input logic w,
                       input logic [31:0] x, input logic b);
        tbl[i] = '{r, v, dt, rd, c, w, x, b};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [39:0] d4, ds;
        int t[3];
        int nt, lowc, budget;
        d4 = {10'h044, 10'h033, 10'h022, 10'h011};
        ds = {10'h044, 10'h155, 10'h022, 10'h011};
        reset_n = 1'b0; req_valid = 4'hF; req_data = d4; stuck = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;

`ifndef PIO_SCHED_READBACK_EN
        row(0,  0, 4'b1111, d4, 4'b0000, 0, 1, 32'h000, 0);
        row(1,  0, 4'b1111, d4, 4'b0000, 0, 1, 32'h000, 0);
        row(2,  1, 4'b1111, d4, 4'b0001, 0, 1, 32'h000, 0);
        row(3,  1, 4'b1111, d4, 4'b0000, 1, 0, 32'h011, 1);
        row(4,  1, 4'b1111, d4, 4'b0010, 0, 1, 32'h011, 0);
        row(5,  1, 4'b1111, d4, 4'b0000, 1, 0, 32'h022, 1);
        row(6,  1, 4'b1111, d4, 4'b0100, 0, 1, 32'h022, 0);
        row(7,  1, 4'b1111, d4, 4'b0000, 1, 0, 32'h033, 1);
        row(8,  1, 4'b1111, d4, 4'b1000, 0, 1, 32'h033, 0);
        row(9,  1, 4'b1111, d4, 4'b0000, 1, 0, 32'h044, 1);
        row(10, 1, 4'b1111, d4, 4'b0001, 0, 1, 32'h044, 0);
        row(11, 1, 4'b1111, d4, 4'b0000, 1, 0, 32'h011, 1);
        row(12, 1, 4'b1111, d4, 4'b0010, 0, 1, 32'h011, 0);
        row(13, 1, 4'b1111, d4, 4'b0000, 1, 0, 32'h022, 1);
        row(14, 1, 4'b0100, ds, 4'b0100, 0, 1, 32'h022, 0);
        row(15, 1, 4'b0000, ds, 4'b0000, 1, 0, 32'h155, 1);
        row(16, 1, 4'b0000, ds, 4'b0000, 0, 1, 32'h155, 0);
        row(17, 1, 4'b0000, ds, 4'b0000, 0, 1, 32'h155, 0);
        for (int i = 0; i < 18; i++) begin
            reset_n = tbl[i].rst_n; req_valid = tbl[i].valid; req_data = tbl[i].data;
            tick();
            check($sformatf("tbl%0d ready", i), 32'(s_ready[0]), 32'(tbl[i].ready));
            check($sformatf("tbl%0d cs", i),    32'(s_cs[0]),    32'(tbl[i].cs));
            check($sformatf("tbl%0d wn", i),    32'(s_wn[0]),    32'(tbl[i].wn));
            check($sformatf("tbl%0d wd", i),    s_wd[0],         tbl[i].wd);
            check($sformatf("tbl%0d busy", i),  32'(s_busy[0]),  32'(tbl[i].busy));
        end
        check("tbl out_port 0x155", 32'(s_out[0]), 32'h155);
`endif

        // ---- dwell spacing on the DWELL_CYCLES=5 instance ----
        reset_n = 1'b0; req_valid = 4'hF; req_data = d4;
        tick(); tick();
        reset_n = 1'b1;
        nt = 0; lowc = 0; budget = 0;
        while (nt < 3 && budget < 60) begin
            tick();
            budget++;
            if (s_cs[1] && !s_wn[1]) begin
                t[nt] = cyc - 1;
                nt++;
            end else if (nt == 1 && !s_busy[1]) begin
                lowc++;
            end
        end
        if (nt < 3) check("dwell strobes seen", 32'(nt), 32'd3);
        else begin
            check("dwell spacing 1", 32'(t[1] - t[0]), 32'(7 + RB));
            check("dwell spacing 2", 32'(t[2] - t[1]), 32'(7 + RB));
            check("dwell busy low cycles", 32'(lowc), 32'd1);
        end

        // ---- reset in the 3rd DWELL cycle ----
        for (int i = 0; i < 2 + RB; i++) tick();
        reset_n = 1'b0; req_valid = 4'b0001;
        tick();
        check("rst-dwell cs",   32'(s_cs[1]),   32'h0);
        check("rst-dwell wn",   32'(s_wn[1]),   32'h1);
        check("rst-dwell busy", 32'(s_busy[1]), 32'h0);
        check("rst-dwell wd",   s_wd[1],        32'h0);
        reset_n = 1'b1;
        tick();
        check("regrant ready", 32'(s_ready[1]), 32'b0001);
        tick();
        check("regrant write", {s_cs[1], s_wn[1]} == 2'b10 ? s_wd[1] : 32'hDEAD, 32'h011);

`ifdef PIO_SCHED_READBACK_EN
        // ---- readback mismatch and err_clr ----
        reset_n = 1'b0; req_valid = 4'b0000; tick();
        reset_n = 1'b1; stuck = 1'b1;
        req_valid = 4'b0001; req_data = {30'b0, 10'h0A5};
        tick();
        req_valid = 4'b0000;
        tick(); tick();
        tick();
        check("rb err set", 32'(s_err[0]), 32'h1);
        tick(); tick();
        check("rb err sticky", 32'(s_err[0]), 32'h1);
        err_clr = 1'b1; tick();
        err_clr = 1'b0; tick();
        check("rb err cleared", 32'(s_err[0]), 32'h0);
        stuck = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        req_valid = 4'b0001; tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        check("rb match no err", 32'(s_err[0]), 32'h0);
`endif

        // ---- randomized traffic ----
        for (int i = 0; i < 800; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            err_clr = ($urandom_range(0, 9) == 0);
            stuck   = ($urandom_range(0, 7) == 0);
            for (int r = 0; r < 4; r++) begin
                if ($urandom_range(0, 5) == 0) begin
                    req_valid[r] = ~req_valid[r];
                    req_data[r*10 +: 10] = 10'($urandom_range(0, 1023));
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
